// File: rtl/lfsr_period_ctrl.sv
// lfsr_period_ctrl
//
// Owns an N-bit Fibonacci LFSR and measures its period in hardware.
// An accepted start latches a seed and tap mask and loads the LFSR with the
// seed. The LFSR then steps once per cycle in which hold is low. The block
// counts steps until the state returns to the seed, or until 2^N steps have
// been taken. It then reports the period, a maximal-length flag and a timeout
// flag, and issues a one-cycle done pulse.
//
// Step function: next = {state[N-2:0], ^(state & taps)}.
//
// Ports:
//   clk      in   1    rising-edge clock
//   reset    in   1    synchronous active-high reset
//   start    in   1    begin a measurement (IDLE only)
//   seed     in   N    initial LFSR state, latched on accepted start
//   taps     in   N    feedback mask, latched on accepted start
//   hold     in   1    freeze stepping while high (RUN only)
//   busy     out  1    high while in RUN
//   done     out  1    one-cycle pulse when results are valid
//   period   out  N+1  steps to return to seed; 0 on timeout or seed error
//   maximal  out  1    period == 2^N - 1
//   timeout  out  1    seed not revisited within 2^N steps
//   seed_err out  1    zero seed rejected (LFSR_SEED_GUARD_EN builds only)
//   lfsr_q   out  N    current LFSR state
//
// Configuration macro: LFSR_SEED_GUARD_EN
//   Defined   : start with seed == 0 skips RUN. DONE is entered directly with
//               seed_err = 1, period = 0 and lfsr_q = 0.
//   Undefined : seed_err is constant 0. A zero seed runs normally and
//               reports period = 1.

module lfsr_period_ctrl #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] seed,
  input  logic [N-1:0] taps,
  input  logic         hold,
  output logic         busy,
  output logic         done,
  output logic [N:0]   period,
  output logic         maximal,
  output logic         timeout,
  output logic         seed_err,
  output logic [N-1:0] lfsr_q
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // 2^N step limit and the maximal-length period 2^N - 1, both N+1 bits wide.
  localparam logic [N:0] LIMIT   = {1'b1, {N{1'b0}}};
  localparam logic [N:0] MAX_LEN = {1'b0, {N{1'b1}}};

  state_t       state;
  logic [N-1:0] seed_q;
  logic [N-1:0] taps_q;
  logic [N:0]   count;
  logic [N:0]   count_inc;
  logic [N-1:0] next;
  logic         seed_reject;

  assign next      = {lfsr_q[N-2:0], ^(lfsr_q & taps_q)};
  assign count_inc = count + 1'b1;

`ifdef LFSR_SEED_GUARD_EN
  assign seed_reject = (seed == '0);
`else
  // Without the guard, the seed_err register below only ever loads 0.
  assign seed_reject = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      seed_q   <= '0;
      taps_q   <= '0;
      count    <= '0;
      lfsr_q   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      period   <= '0;
      maximal  <= 1'b0;
      timeout  <= 1'b0;
      seed_err <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            seed_q   <= seed;
            taps_q   <= taps;
            count    <= '0;
            period   <= '0;
            maximal  <= 1'b0;
            timeout  <= 1'b0;
            seed_err <= 1'b0;
            if (seed_reject) begin
              lfsr_q   <= '0;
              seed_err <= 1'b1;
              done     <= 1'b1;
              state    <= DONE;
            end else begin
              lfsr_q <= seed;
              busy   <= 1'b1;
              state  <= RUN;
            end
          end
        end

        RUN: begin
          if (!hold) begin
            lfsr_q <= next;
            count  <= count_inc;
            // A match wins over the limit when both happen on the same step.
            if (next == seed_q) begin
              period  <= count_inc;
              maximal <= (count_inc == MAX_LEN);
              busy    <= 1'b0;
              done    <= 1'b1;
              state   <= DONE;
            end else if (count_inc == LIMIT) begin
              // Covers non-invertible tap masks (taps[N-1] = 0), where the
              // seed may never recur.
              timeout <= 1'b1;
              period  <= '0;
              busy    <= 1'b0;
              done    <= 1'b1;
              state   <= DONE;
            end
          end
        end

        DONE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_period_ctrl.sv
// Directed bench for lfsr_period_ctrl (N = 4).
// Each measurement pushes its expected result onto a scoreboard queue when
// start is driven. The entry is popped and compared when done pulses.

module tb_lfsr_period_ctrl;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         hold;
  logic [N-1:0] seed;
  logic [N-1:0] taps;
  logic         busy;
  logic         done;
  logic [N:0]   period;
  logic         maximal;
  logic         timeout;
  logic         seed_err;
  logic [N-1:0] lfsr_q;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string      tag;
    int         cyc;
    int         period;
    bit         maximal;
    bit         timeout;
    bit         seed_err;
    logic [3:0] final_q;
  } exp_t;

  exp_t sb[$];

  // Expected LFSR states for taps 1001 and seed 0001, indexed by cycle.
  logic [3:0] max_seq [0:15];

  always #5 clk = ~clk;

  lfsr_period_ctrl #(.N(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .seed     (seed),
    .taps     (taps),
    .hold     (hold),
    .busy     (busy),
    .done     (done),
    .period   (period),
    .maximal  (maximal),
    .timeout  (timeout),
    .seed_err (seed_err),
    .lfsr_q   (lfsr_q)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One measurement. Cycle 0 is the cycle after the edge that samples start.
  // A hold value set in cycle c stalls edge c+1.
  task automatic run(input string tag, input logic [3:0] s, input logic [3:0] t,
                     input int hold_from, input int hold_len, input int extra_start_at,
                     input bit check_seq, input exp_t e);
    int   cyc;
    bit   got;
    exp_t x;
    e.tag = tag;
    sb.push_back(e);
    seed  = s;
    taps  = t;
    start = 1'b1;
    hold  = 1'b0;
    tick();
    start = 1'b0;
    cyc   = 0;
    got   = 1'b0;
    while (!got && cyc < 60) begin
      if (done) begin
        got = 1'b1;
      end else begin
        check($sformatf("%s_busy_c%0d", tag, cyc), 32'(busy), 32'd1);
        if (check_seq && cyc < 16)
          check($sformatf("%s_lfsr_c%0d", tag, cyc), 32'(lfsr_q), 32'(max_seq[cyc]));
        hold  = (cyc >= hold_from) && (cyc < hold_from + hold_len);
        start = (cyc == extra_start_at);
        // The ignored start also carries a different seed and tap mask.
        seed  = (cyc == extra_start_at) ? ~s : s;
        taps  = (cyc == extra_start_at) ? ~t : t;
        tick();
        cyc++;
      end
    end
    hold  = 1'b0;
    start = 1'b0;
    seed  = s;
    taps  = t;
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    if (got && sb.size() > 0) begin
      x = sb.pop_front();
      check({x.tag, "_done_cycle"}, 32'(cyc), 32'(x.cyc));
      check({x.tag, "_period"}, 32'(period), 32'(x.period));
      check({x.tag, "_maximal"}, 32'(maximal), 32'(x.maximal));
      check({x.tag, "_timeout"}, 32'(timeout), 32'(x.timeout));
      check({x.tag, "_seed_err"}, 32'(seed_err), 32'(x.seed_err));
      check({x.tag, "_busy_at_done"}, 32'(busy), 32'd0);
      check({x.tag, "_final_lfsr"}, 32'(lfsr_q), 32'(x.final_q));
      tick();
      check({x.tag, "_done_one_cycle"}, 32'(done), 32'd0);
      check({x.tag, "_period_held"}, 32'(period), 32'(x.period));
    end else begin
      sb.delete();
    end
    // Second dead cycle before the next start.
    tick();
  endtask

  initial begin
    exp_t e;
    int   pulses;

    max_seq[0]  = 4'b0001; max_seq[1]  = 4'b0011; max_seq[2]  = 4'b0111;
    max_seq[3]  = 4'b1111; max_seq[4]  = 4'b1110; max_seq[5]  = 4'b1101;
    max_seq[6]  = 4'b1010; max_seq[7]  = 4'b0101; max_seq[8]  = 4'b1011;
    max_seq[9]  = 4'b0110; max_seq[10] = 4'b1100; max_seq[11] = 4'b1001;
    max_seq[12] = 4'b0010; max_seq[13] = 4'b0100; max_seq[14] = 4'b1000;
    max_seq[15] = 4'b0001;

    reset = 1'b1;
    start = 1'b0;
    hold  = 1'b0;
    seed  = '0;
    taps  = '0;
    tick();
    tick();
    reset = 1'b0;

    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_period", 32'(period), 32'd0);
    check("rst_maximal", 32'(maximal), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_seed_err", 32'(seed_err), 32'd0);
    check("rst_lfsr", 32'(lfsr_q), 32'd0);

    // Maximal tap set, with the state sequence checked in every cycle.
    e = '{tag: "", cyc: 15, period: 15, maximal: 1'b1, timeout: 1'b0, seed_err: 1'b0, final_q: 4'b0001};
    run("maximal", 4'b0001, 4'b1001, 99, 0, -1, 1'b1, e);

    // Rotation: period 4.
    e = '{tag: "", cyc: 4, period: 4, maximal: 1'b0, timeout: 1'b0, seed_err: 1'b0, final_q: 4'b0001};
    run("rotate", 4'b0001, 4'b1000, 99, 0, -1, 1'b0, e);

    // Non-invertible: the state reaches 0000 and never returns to 0010.
    e = '{tag: "", cyc: 16, period: 0, maximal: 1'b0, timeout: 1'b1, seed_err: 1'b0, final_q: 4'b0000};
    run("timeout", 4'b0010, 4'b0001, 99, 0, -1, 1'b0, e);

    // Zero seed.
`ifdef LFSR_SEED_GUARD_EN
    e = '{tag: "", cyc: 0, period: 0, maximal: 1'b0, timeout: 1'b0, seed_err: 1'b1, final_q: 4'b0000};
`else
    e = '{tag: "", cyc: 1, period: 1, maximal: 1'b0, timeout: 1'b0, seed_err: 1'b0, final_q: 4'b0000};
`endif
    run("zero_seed", 4'b0000, 4'b1001, 99, 0, -1, 1'b0, e);

    // Three hold cycles plus an ignored start during RUN.
    e = '{tag: "", cyc: 18, period: 15, maximal: 1'b1, timeout: 1'b0, seed_err: 1'b0, final_q: 4'b0001};
    run("hold_start", 4'b0001, 4'b1001, 5, 3, 3, 1'b0, e);

    // Reset asserted in cycle 7 of a maximal run.
    seed  = 4'b0001;
    taps  = 4'b1001;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 7; c++) tick();
    check("abort_lfsr_c7", 32'(lfsr_q), 32'(max_seq[7]));
    check("abort_busy_c7", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_period", 32'(period), 32'd0);
    check("abort_maximal", 32'(maximal), 32'd0);
    check("abort_timeout", 32'(timeout), 32'd0);
    check("abort_seed_err", 32'(seed_err), 32'd0);
    check("abort_lfsr", 32'(lfsr_q), 32'd0);
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (done || busy) pulses++;
    end
    check("abort_no_done", 32'(pulses), 32'd0);

    // A fresh start after the abort.
    e = '{tag: "", cyc: 15, period: 15, maximal: 1'b1, timeout: 1'b0, seed_err: 1'b0, final_q: 4'b0001};
    run("after_abort", 4'b0001, 4'b1001, 99, 0, -1, 1'b0, e);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
